// File: rtl/gemm_seq_pkg.sv
// Shared types and helpers for the tiled GEMM sequencer.
package gemm_seq_pkg;

  // Widest supported runtime dimension; the top zero-extends its cfg ports into this.
  localparam int unsigned CfgMaxW = 16;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StLoad,
    StCapt,
    StPush,
    StDrain,
    StWrite,
    StDone
  } state_e;

  typedef struct packed {
    logic [CfgMaxW-1:0] m;
    logic [CfgMaxW-1:0] n;
    logic [CfgMaxW-1:0] k;
  } cfg_t;

  function automatic int unsigned lane_lsb(int unsigned lane, int unsigned dw);
    return lane * dw;
  endfunction

endpackage

// File: rtl/gemm_seq_addr.sv
// Combinational memory address and in-range flag for the current load or write slot.
module gemm_seq_addr
  import gemm_seq_pkg::*;
#(
  parameter int unsigned M_TILE = 2,
  parameter int unsigned K_TILE = 2,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned SLOT_WIDTH = 3,
  parameter logic [ADDR_WIDTH-1:0] X_BASE = 32'h2000,
  parameter logic [ADDR_WIDTH-1:0] W_BASE = 32'h1000,
  parameter logic [ADDR_WIDTH-1:0] Y_BASE = 32'h3000
) (
  input  logic [2:0]            phase_i,
  input  logic [CfgMaxW-1:0]    n_i,
  input  logic [CfgMaxW-1:0]    mt_i,
  input  logic [CfgMaxW-1:0]    kt_i,
  input  logic [SLOT_WIDTH-1:0] slot_i,
  input  logic [CfgMaxW-1:0]    cfg_m_i,
  input  logic [CfgMaxW-1:0]    cfg_k_i,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic                  in_range_o
);

  localparam int unsigned IdxW = CfgMaxW + 8;

  state_e          phase;
  logic [IdxW-1:0] m_base, k_base, slot_ext, idx_m, idx_k;

  assign phase    = state_e'(phase_i);
  assign m_base   = IdxW'(mt_i) * IdxW'(M_TILE);
  assign k_base   = IdxW'(kt_i) * IdxW'(K_TILE);
  assign slot_ext = IdxW'(slot_i);

  always_comb begin
    addr_o     = '0;
    in_range_o = 1'b0;
    idx_m      = '0;
    idx_k      = '0;
    if (phase == StLoad) begin
      // Slots below M_TILE fetch X lanes, the rest fetch W lanes.
      if (slot_ext < IdxW'(M_TILE)) begin
        idx_m      = m_base + slot_ext;
        in_range_o = idx_m < IdxW'(cfg_m_i);
        addr_o     = X_BASE + ADDR_WIDTH'(n_i) * ADDR_WIDTH'(cfg_m_i) + ADDR_WIDTH'(idx_m);
      end else begin
        idx_k      = k_base + slot_ext - IdxW'(M_TILE);
        in_range_o = idx_k < IdxW'(cfg_k_i);
        addr_o     = W_BASE + ADDR_WIDTH'(n_i) * ADDR_WIDTH'(cfg_k_i) + ADDR_WIDTH'(idx_k);
      end
    end else if (phase == StWrite) begin
      idx_m      = m_base + slot_ext / IdxW'(K_TILE);
      idx_k      = k_base + slot_ext % IdxW'(K_TILE);
      in_range_o = (idx_m < IdxW'(cfg_m_i)) && (idx_k < IdxW'(cfg_k_i));
      addr_o     = Y_BASE + ADDR_WIDTH'(idx_m) * ADDR_WIDTH'(cfg_k_i) + ADDR_WIDTH'(idx_k);
    end
  end

endmodule

// File: rtl/gemm_tile_sequencer.sv
// Tiled Y = X^T * W sequencer: streams operands from a single-port memory into a
// fixed systolic array tile by tile and writes the drained results back.
module gemm_tile_sequencer
  import gemm_seq_pkg::*;
#(
  parameter int unsigned M_TILE = 2,
  parameter int unsigned K_TILE = 2,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned CFG_WIDTH = 16,
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter logic [ADDR_WIDTH-1:0] X_BASE = 32'h2000,
  parameter logic [ADDR_WIDTH-1:0] W_BASE = 32'h1000,
  parameter logic [ADDR_WIDTH-1:0] Y_BASE = 32'h3000
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic [CFG_WIDTH-1:0]                  cfg_m,
  input  logic [CFG_WIDTH-1:0]                  cfg_n,
  input  logic [CFG_WIDTH-1:0]                  cfg_k,
  output logic                                  busy,
  output logic                                  done,
  output logic [ADDR_WIDTH-1:0]                 mem_addr,
  output logic                                  mem_rd_en,
  input  logic [DATA_WIDTH-1:0]                 mem_rd_data,
  output logic                                  mem_wr_en,
  output logic [DATA_WIDTH-1:0]                 mem_wr_data,
  output logic                                  arr_clr,
  output logic                                  arr_valid,
  output logic [DATA_WIDTH*M_TILE-1:0]          arr_x,
  output logic [DATA_WIDTH*K_TILE-1:0]          arr_w,
  input  logic [DATA_WIDTH*M_TILE*K_TILE-1:0]   arr_y
);

  localparam int unsigned L       = M_TILE + K_TILE;
  localparam int unsigned MK      = M_TILE * K_TILE;
  localparam int unsigned SlotMax = (L > MK) ? L : MK;
  localparam int unsigned SlotW   = $clog2(SlotMax + 1);
  localparam int unsigned DrW     = $clog2(DRAIN_CYCLES + 1);
  localparam int unsigned IdxW    = CfgMaxW + 8;

  state_e                       state_q, state_d;
  cfg_t                         cfg_q, cfg_d;
  logic [CfgMaxW-1:0]           n_q, n_d, mt_q, mt_d, kt_q, kt_d;
  logic [SlotW-1:0]             slot_q, slot_d, rd_slot_q;
  logic [DrW-1:0]               drain_q, drain_d;
  logic                         rd_pend_q, rd_inr_q;
  logic [DATA_WIDTH*M_TILE-1:0] x_stage_q, x_stage_d, arr_x_q, arr_x_d;
  logic [DATA_WIDTH*K_TILE-1:0] w_stage_q, w_stage_d, arr_w_q, arr_w_d;
  logic                         busy_q, done_q, rd_en_q, wr_en_q, clr_q, valid_q;
  logic [ADDR_WIDTH-1:0]        addr_q, addr_d, slot_addr;
  logic [DATA_WIDTH-1:0]        wr_data_q, wr_data_d;
  logic                         slot_inr, kt_last, mt_last;
  logic [IdxW-1:0]              k_next_base, m_next_base;

  assign k_next_base = (IdxW'(kt_q) + IdxW'(1)) * IdxW'(K_TILE);
  assign m_next_base = (IdxW'(mt_q) + IdxW'(1)) * IdxW'(M_TILE);
  assign kt_last     = k_next_base >= IdxW'(cfg_q.k);
  assign mt_last     = m_next_base >= IdxW'(cfg_q.m);

  always_comb begin
    state_d = state_q;
    cfg_d   = cfg_q;
    n_d     = n_q;
    mt_d    = mt_q;
    kt_d    = kt_q;
    slot_d  = slot_q;
    drain_d = drain_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          cfg_d.m = CfgMaxW'(cfg_m);
          cfg_d.n = CfgMaxW'(cfg_n);
          cfg_d.k = CfgMaxW'(cfg_k);
          mt_d    = '0;
          kt_d    = '0;
          n_d     = '0;
          slot_d  = '0;
          state_d = (cfg_m == '0 || cfg_n == '0 || cfg_k == '0) ? StDone : StClear;
        end
      end
      StClear: state_d = StLoad;
      StLoad: begin
        if (slot_q == SlotW'(L - 1)) state_d = StCapt;
        else slot_d = slot_q + SlotW'(1);
      end
      StCapt: state_d = StPush;
      StPush: begin
        n_d    = n_q + CfgMaxW'(1);
        slot_d = '0;
        if (n_d < cfg_q.n) begin
          state_d = StLoad;
        end else begin
          state_d = StDrain;
          drain_d = '0;
        end
      end
      StDrain: begin
        if (drain_q == DrW'(DRAIN_CYCLES - 1)) begin
          state_d = StWrite;
          slot_d  = '0;
        end else begin
          drain_d = drain_q + DrW'(1);
        end
      end
      StWrite: begin
        if (slot_q == SlotW'(MK - 1)) begin
          n_d    = '0;
          slot_d = '0;
          if (!kt_last) begin
            kt_d    = kt_q + CfgMaxW'(1);
            state_d = StClear;
          end else if (!mt_last) begin
            kt_d    = '0;
            mt_d    = mt_q + CfgMaxW'(1);
            state_d = StClear;
          end else begin
            state_d = StDone;
          end
        end else begin
          slot_d = slot_q + SlotW'(1);
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered, so they are decoded from the next-cycle state and counters.
  gemm_seq_addr #(
    .M_TILE     (M_TILE),
    .K_TILE     (K_TILE),
    .ADDR_WIDTH (ADDR_WIDTH),
    .SLOT_WIDTH (SlotW),
    .X_BASE     (X_BASE),
    .W_BASE     (W_BASE),
    .Y_BASE     (Y_BASE)
  ) u_addr (
    .phase_i    (state_d),
    .n_i        (n_d),
    .mt_i       (mt_d),
    .kt_i       (kt_d),
    .slot_i     (slot_d),
    .cfg_m_i    (cfg_d.m),
    .cfg_k_i    (cfg_d.k),
    .addr_o     (slot_addr),
    .in_range_o (slot_inr)
  );

  // Read data lands one cycle after the strobe; rd_*_q remember which slot it belongs to.
  always_comb begin
    x_stage_d = x_stage_q;
    w_stage_d = w_stage_q;
    if (rd_pend_q) begin
      if (rd_slot_q < SlotW'(M_TILE)) begin
        x_stage_d[lane_lsb(32'(rd_slot_q), DATA_WIDTH) +: DATA_WIDTH] =
            rd_inr_q ? mem_rd_data : '0;
      end else begin
        w_stage_d[lane_lsb(32'(rd_slot_q) - M_TILE, DATA_WIDTH) +: DATA_WIDTH] =
            rd_inr_q ? mem_rd_data : '0;
      end
    end
    arr_x_d   = (state_d == StPush) ? x_stage_d : arr_x_q;
    arr_w_d   = (state_d == StPush) ? w_stage_d : arr_w_q;
    addr_d    = (state_d == StLoad || state_d == StWrite) ? slot_addr : '0;
    wr_data_d = '0;
    if (state_d == StWrite) begin
      wr_data_d = arr_y[lane_lsb(32'(slot_d), DATA_WIDTH) +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cfg_q     <= '0;
      n_q       <= '0;
      mt_q      <= '0;
      kt_q      <= '0;
      slot_q    <= '0;
      drain_q   <= '0;
      rd_pend_q <= 1'b0;
      rd_slot_q <= '0;
      rd_inr_q  <= 1'b0;
      x_stage_q <= '0;
      w_stage_q <= '0;
      arr_x_q   <= '0;
      arr_w_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      clr_q     <= 1'b0;
      valid_q   <= 1'b0;
      addr_q    <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cfg_q     <= cfg_d;
      n_q       <= n_d;
      mt_q      <= mt_d;
      kt_q      <= kt_d;
      slot_q    <= slot_d;
      drain_q   <= drain_d;
      rd_pend_q <= (state_q == StLoad);
      rd_slot_q <= slot_q;
      rd_inr_q  <= rd_en_q;
      x_stage_q <= x_stage_d;
      w_stage_q <= w_stage_d;
      arr_x_q   <= arr_x_d;
      arr_w_q   <= arr_w_d;
      busy_q    <= (state_d != StIdle);
      done_q    <= (state_d == StDone);
      rd_en_q   <= (state_d == StLoad) && slot_inr;
      wr_en_q   <= (state_d == StWrite) && slot_inr;
      clr_q     <= (state_d == StClear);
      valid_q   <= (state_d == StPush);
      addr_q    <= addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign mem_addr    = addr_q;
  assign mem_rd_en   = rd_en_q;
  assign mem_wr_en   = wr_en_q;
  assign mem_wr_data = wr_data_q;
  assign arr_clr     = clr_q;
  assign arr_valid   = valid_q;
  assign arr_x       = arr_x_q;
  assign arr_w       = arr_w_q;

endmodule

// File: tb/tb_gemm_tile_sequencer.sv
// Scoreboard bench: a reference GEMM queues expected array steps, writes and timing;
// a monitor pops and compares as the sequencer produces them.
module tb_gemm_tile_sequencer;

  localparam int unsigned MT = 2;
  localparam int unsigned KT = 2;
  localparam int unsigned DW = 32;
  localparam int unsigned L  = MT + KT;
  localparam int unsigned DR = 3;
  localparam logic [31:0] XB = 32'h2000;
  localparam logic [31:0] WB = 32'h1000;
  localparam logic [31:0] YB = 32'h3000;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  start = 1'b0;
  logic [15:0]           cfg_m = '0, cfg_n = '0, cfg_k = '0;
  logic                  busy, done, mem_rd_en, mem_wr_en, arr_clr, arr_valid;
  logic [31:0]           mem_addr, mem_wr_data;
  logic [31:0]           mem_rd_data = '0;
  logic [DW*MT-1:0]      arr_x;
  logic [DW*KT-1:0]      arr_w;
  logic [DW*MT*KT-1:0]   arr_y;

  gemm_tile_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .cfg_m       (cfg_m),
    .cfg_n       (cfg_n),
    .cfg_k       (cfg_k),
    .busy        (busy),
    .done        (done),
    .mem_addr    (mem_addr),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_data (mem_rd_data),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_data (mem_wr_data),
    .arr_clr     (arr_clr),
    .arr_valid   (arr_valid),
    .arr_x       (arr_x),
    .arr_w       (arr_w),
    .arr_y       (arr_y)
  );

  always #5 clk = ~clk;

  int          cyc = 0;
  int          start_cyc = 0;
  int          total = 0;
  int          bad = 0;
  bit          done_seen = 0;
  int          cur_m = 0, cur_n = 0, cur_k = 0;
  logic [31:0] mem [0:16383];
  logic [31:0] acc [MT][KT];

  typedef struct { int cyc; logic [DW*MT-1:0] x; logic [DW*KT-1:0] w; } push_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
  push_t exp_push[$];
  wr_t   exp_wr[$];
  int    exp_clr[$];
  int    exp_done[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Read-only operand memory with one-cycle read latency.
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_addr[13:0]];

  // Behavioural systolic array: accumulate x_i*w_j per step.
  always @(posedge clk) begin
    for (int i = 0; i < MT; i++)
      for (int j = 0; j < KT; j++)
        if (arr_clr) acc[i][j] <= '0;
        else if (arr_valid) acc[i][j] <= acc[i][j] + arr_x[i*DW +: DW] * arr_w[j*DW +: DW];
  end

  always @* begin
    arr_y = '0;
    for (int i = 0; i < MT; i++)
      for (int j = 0; j < KT; j++) arr_y[(i*KT+j)*DW +: DW] = acc[i][j];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: event at cycle %0d with nothing expected", name, cyc - start_cyc);
  endtask

  task automatic monitor();
    push_t p;
    wr_t   w;
    int    rel;
    bit    in_x, in_w;
    forever begin
      @(negedge clk);
      if (!rst) begin
        rel = cyc - start_cyc;
        check("rd_wr_exclusive", 64'(mem_rd_en & mem_wr_en), 64'd0);
        if (mem_rd_en) begin
          in_x = (mem_addr >= XB) && (mem_addr < XB + 32'(cur_n * cur_m));
          in_w = (mem_addr >= WB) && (mem_addr < WB + 32'(cur_n * cur_k));
          check("rd_addr_legal", 64'(in_x | in_w), 64'd1);
        end
        if (arr_clr) begin
          if (exp_clr.size() == 0) fail("clr_unexpected");
          else check("clr_cycle", 64'(rel), 64'(exp_clr.pop_front()));
        end
        if (arr_valid) begin
          if (exp_push.size() == 0) fail("push_unexpected");
          else begin
            p = exp_push.pop_front();
            check("push_cycle", 64'(rel), 64'(p.cyc));
            check("arr_x", 64'(arr_x), 64'(p.x));
            check("arr_w", 64'(arr_w), 64'(p.w));
          end
        end
        if (mem_wr_en) begin
          if (exp_wr.size() == 0) fail("write_unexpected");
          else begin
            w = exp_wr.pop_front();
            check("wr_addr", 64'(mem_addr), 64'(w.addr));
            check("wr_data", 64'(mem_wr_data), 64'(w.data));
          end
        end
        if (done) begin
          done_seen = 1;
          if (exp_done.size() == 0) fail("done_unexpected");
          else check("done_cycle", 64'(rel), 64'(exp_done.pop_front()));
        end
      end
    end
  endtask

  // Fill operands, queue the reference GEMM's expectations, then launch and wait.
  task automatic run(input int m, input int n, input int k, input bit ramp,
                     input int poke_at, input int abort_at);
    int          mtn, ktn, tt, t, budget, dcyc;
    logic [31:0] y;
    push_t       p;
    bit          aborted;
    for (int i = 0; i < n * m; i++) mem[14'(XB + 32'(i))] = ramp ? 32'(i + 1) : $urandom;
    for (int i = 0; i < n * k; i++) mem[14'(WB + 32'(i))] = ramp ? 32'(2 * i + 1) : $urandom;
    cur_m = m; cur_n = n; cur_k = k;
    mtn = (m + MT - 1) / MT;
    ktn = (k + KT - 1) / KT;
    tt  = 1 + n * (L + 2) + DR + MT * KT;
    dcyc = (m == 0 || n == 0 || k == 0) ? 1 : 1 + mtn * ktn * tt;
    exp_done.push_back(dcyc);
    if (dcyc != 1) begin
      for (int mt = 0; mt < mtn; mt++)
        for (int kt = 0; kt < ktn; kt++) begin
          t = mt * ktn + kt;
          exp_clr.push_back(1 + t * tt);
          for (int s = 0; s < n; s++) begin
            p.cyc = 1 + t * tt + 1 + s * (L + 2) + L + 1;
            p.x = '0;
            p.w = '0;
            for (int i = 0; i < MT; i++)
              if (mt * MT + i < m) p.x[i*DW +: DW] = mem[14'(XB + 32'(s * m + mt * MT + i))];
            for (int j = 0; j < KT; j++)
              if (kt * KT + j < k) p.w[j*DW +: DW] = mem[14'(WB + 32'(s * k + kt * KT + j))];
            exp_push.push_back(p);
          end
          for (int i = 0; i < MT; i++)
            for (int j = 0; j < KT; j++)
              if (mt * MT + i < m && kt * KT + j < k) begin
                y = '0;
                for (int s = 0; s < n; s++)
                  y += mem[14'(XB + 32'(s * m + mt * MT + i))] *
                       mem[14'(WB + 32'(s * k + kt * KT + j))];
                exp_wr.push_back('{addr: YB + 32'((mt * MT + i) * k + kt * KT + j), data: y});
              end
        end
    end
    done_seen = 0;
    aborted = 0;
    @(posedge clk); #1;
    start = 1; cfg_m = 16'(m); cfg_n = 16'(n); cfg_k = 16'(k);
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 0;
    check("busy_cycle1", 64'(busy), 64'd1);
    budget = dcyc + 40;
    for (int c = 1; c < budget && !done_seen && !aborted; c++) begin
      if (c == poke_at) begin
        start = 1; cfg_m = 16'd5; cfg_n = 16'd3; cfg_k = 16'd7;
      end else start = 0;
      if (c == abort_at) begin
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_rd_en", 64'(mem_rd_en), 64'd0);
        check("abort_wr_en", 64'(mem_wr_en), 64'd0);
        check("abort_clr_valid", 64'({arr_clr, arr_valid}), 64'd0);
        check("abort_addr", 64'(mem_addr), 64'd0);
        check("abort_lanes", 64'(arr_x | arr_w), 64'd0);
        exp_push.delete(); exp_wr.delete(); exp_clr.delete(); exp_done.delete();
        aborted = 1;
      end else begin
        @(posedge clk); #1;
      end
    end
    start = 0;
    if (aborted) begin
      repeat (30) @(posedge clk);
      #1;
    end else begin
      if (!done_seen) begin
        total++; bad++;
        $display("FAIL done_timeout: no done within %0d cycles, expected at %0d", budget, dcyc);
      end
      check("busy_after_done", 64'(busy), 64'd0);
      check("writes_left", 64'(exp_wr.size()), 64'd0);
      check("pushes_left", 64'(exp_push.size()), 64'd0);
      check("clears_left", 64'(exp_clr.size()), 64'd0);
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic stimulus();
    for (int i = 0; i < 16384; i++) mem[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_strobes", 64'({mem_rd_en, mem_wr_en, arr_clr, arr_valid}), 64'd0);
    check("rst_addr", 64'(mem_addr), 64'd0);
    check("rst_wr_data", 64'(mem_wr_data), 64'd0);
    check("rst_lanes", 64'(arr_x | arr_w), 64'd0);
    run(1, 27, 2, 1, 0, 0);
    run(3, 4, 3, 0, 0, 0);
    run(3, 4, 0, 0, 0, 0);
    run(1, 27, 2, 0, 50, 0);
    run(1, 27, 2, 1, 0, 40);
    run(1, 27, 2, 1, 0, 0);
    for (int r = 0; r < 5; r++)
      run(int'($urandom_range(1, 5)), int'($urandom_range(1, 6)),
          int'($urandom_range(1, 5)), 0, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  endtask

  initial begin
    fork
      monitor();
      stimulus();
    join_any
  end

endmodule
